// File: rtl/mem_router.sv
// Address-decoding router: one master onto CNT slaves, responses returned in request order.
// Optional local decode-error responder enabled by defining MEM_ROUTER_DECERR_EN.
module mem_router #(
  parameter int CNT         = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE [CNT] = '{32'h0000_0000, 32'h1000_0000},
  parameter logic [ADDR_WIDTH-1:0] MASK [CNT] = '{32'hF000_0000, 32'hF000_0000}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           master_req_valid,
  output logic                           master_req_ready,
  input  logic [ADDR_WIDTH-1:0]          master_req_addr,
  input  logic [DATA_WIDTH-1:0]          master_req_data,
  output logic                           master_resp_valid,
  input  logic                           master_resp_ready,
  output logic [DATA_WIDTH-1:0]          master_resp_data,
  output logic [CNT-1:0]                 slave_req_valid,
  input  logic [CNT-1:0]                 slave_req_ready,
  output logic [ADDR_WIDTH-1:0]          slave_req_addr,
  output logic [DATA_WIDTH-1:0]          slave_req_data,
  input  logic [CNT-1:0]                 slave_resp_valid,
  output logic [CNT-1:0]                 slave_resp_ready,
  input  logic [CNT-1:0][DATA_WIDTH-1:0] slave_resp_data
);

`ifdef MEM_ROUTER_DECERR_EN
  localparam int NIDX        = CNT + 1;
  localparam int DEFAULT_IDX = CNT;
`else
  localparam int NIDX        = CNT;
  localparam int DEFAULT_IDX = CNT - 1;
`endif
  localparam int IDXW = (NIDX > 1) ? $clog2(NIDX) : 1;
  localparam int PTRW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNTW = $clog2(QUEUE_DEPTH + 1);

  logic [IDXW-1:0] sel;
  logic            sel_ready;
  logic            q_enq_ready;
  logic            enq_fire;
  logic            q_deq_valid;
  logic [IDXW-1:0] q_head;
  logic            head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic            deq_fire;

  logic [IDXW-1:0] q_mem [QUEUE_DEPTH];
  logic [PTRW-1:0] head_ptr;
  logic [PTRW-1:0] tail_ptr;
  logic [CNTW-1:0] q_count;

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(QUEUE_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Lowest matching slave wins; unmapped addresses fall to the default index.
  always_comb begin
    sel = IDXW'(DEFAULT_IDX);
    for (int i = CNT - 1; i >= 0; i--) begin
      if ((master_req_addr & MASK[i]) == BASE[i]) sel = IDXW'(i);
    end
  end

  always_comb begin
    sel_ready = 1'b1;
    for (int i = 0; i < CNT; i++) begin
      if (sel == IDXW'(i)) sel_ready = slave_req_ready[i];
    end
  end

  assign q_enq_ready      = (q_count != CNTW'(QUEUE_DEPTH));
  assign master_req_ready = sel_ready && q_enq_ready && !rst;
  assign enq_fire         = master_req_valid && master_req_ready;
  assign slave_req_addr   = master_req_addr;
  assign slave_req_data   = master_req_data;

  always_comb begin
    slave_req_valid = '0;
    for (int i = 0; i < CNT; i++) begin
      slave_req_valid[i] = master_req_valid && (sel == IDXW'(i)) && q_enq_ready && !rst;
    end
  end

  // An empty queue forwards the entry being enqueued so a combinational slave can answer in-cycle.
  assign q_deq_valid = (q_count != '0) || enq_fire;
  assign q_head      = (q_count == '0) ? sel : q_mem[head_ptr];

  // A head index with no slave behind it is the local error responder: always valid, zero data.
  always_comb begin
    head_valid = 1'b1;
    head_data  = '0;
    for (int i = 0; i < CNT; i++) begin
      if (q_head == IDXW'(i)) begin
        head_valid = slave_resp_valid[i];
        head_data  = slave_resp_data[i];
      end
    end
  end

  assign master_resp_valid = q_deq_valid && head_valid && !rst;
  assign master_resp_data  = head_data;
  assign deq_fire          = master_resp_valid && master_resp_ready;

  always_comb begin
    slave_resp_ready = '0;
    for (int i = 0; i < CNT; i++) begin
      slave_resp_ready[i] = q_deq_valid && (q_head == IDXW'(i)) && master_resp_ready && !rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      q_count  <= '0;
    end else begin
      if (enq_fire) begin
        q_mem[tail_ptr] <= sel;
        tail_ptr        <= next_ptr(tail_ptr);
      end
      if (deq_fire) head_ptr <= next_ptr(head_ptr);
      q_count <= q_count + CNTW'(enq_fire) - CNTW'(deq_fire);
    end
  end

endmodule
